mw8080_input_ports: RTL and testbench
=====================================

// Module: mw8080_input_ports
// PURPOSE
//  Parametrised player-input front end for Midway/Taito 8080 cores. It sits between
//  arcade_inputs/DIP status and the CPU input bus (GDB0..GDB3 of invaderst).
//  Synchronises and debounces all controls, applies joystick swap, and shapes coins
//  into fixed-width pulses through a small queue. Also latches tilt, counts coins
//  and applies per-port polarity, so each game only sets parameters.
// PARAMETERS
//  NUM_PLAYERS       2      players wired, 1..4; absent player bits read inactive
//  DEBOUNCE_CYCLES   1024   stable cycles before a debounced bit changes; 0 = bypass
//  COIN_PULSE_CYCLES 65536  active width of each coin pulse on GDB1[3]
//  COIN_GAP_CYCLES   65536  forced inactive time between queued pulses
//  COIN_QUEUE        3      max pending coins (saturating); further coins are dropped
//  INV0..INV3        8'h00  XOR mask applied to GDB0..GDB3 (active-low boards)
// PORTS
//  Clk        in   1                  system clock
//  Rst_n      in   1                  async active-low reset
//  joy_in     in   4*NUM_PLAYERS      per player {up,down,right,left}, player0 in LSBs
//  start_in   in   NUM_PLAYERS        start buttons, bit0 = 1P
//  coin_in    in   1                  coin switch, active high
//  tilt_in    in   1                  tilt switch, active high
//  joyswap    in   1                  swap players 0/1 (ignored if NUM_PLAYERS<2)
//  dip        in   8                  DIP switches, passed undebounced
//  GDB0       out  8                  {p1 u,d,r,l, p0 u,d,r,l} ^ INV0
//  GDB1       out  8                  {tilt,st3,st2,0,coin,0,st1,st0} ^ INV1
//  GDB2       out  8                  dip ^ INV2
//  GDB3       out  8                  {p3 u,d,r,l, p2 u,d,r,l} ^ INV3
//  coin_count out  8                  accepted coins, wraps 255->0
//  coin_drop  out  1                  1-cycle strobe: coin lost, queue full
// BEHAVIOUR
//  - Reset: all sync/debounce state 0, queue 0, FSM IDLE, tilt 0, coin_count 0,
//    coin_drop 0, GDBn = INVn. Asserting reset mid-pulse ends the pulse at once.
//  - Sync: 2-FF on every joy/start/coin/tilt bit; dip is sampled once (1 FF).
//  - Debounce, per bit: a counter counts while synced != stable and clears when they
//    match. When the count reaches DEBOUNCE_CYCLES, stable takes the synced value.
//  - Latency from a raw edge held steady to the GDB output is 2+DEBOUNCE_CYCLES+1
//    cycles. A glitch shorter than DEBOUNCE_CYCLES produces no output change.
//  - Swap: applied after debounce and is combinational into the GDB register.
//    A joyswap change is visible on the next cycle, with no debounce.
//  - Tilt: a debounced rising edge sets a sticky latch; only Rst_n clears it.
//  - Coin queue and counter:
//    - A debounced coin rising edge increments the queue and coin_count.
//    - If queue==COIN_QUEUE, the coin instead pulses coin_drop and is not counted.
//  - Coin FSM:
//    - IDLE : queue>0 -> PULSE, queue-1, load COIN_PULSE_CYCLES-1.
//    - PULSE: coin bit=1; count down; at 0 -> GAP, load COIN_GAP_CYCLES-1.
//    - GAP  : coin bit=0; count down; at 0 -> IDLE.
//    - Edge and FSM dequeue in the same cycle: net queue change 0; the coin is never lost.
//  - GDB outputs are registered; unused bits are 0 before the INV XOR.
// TESTING (sim: DEBOUNCE=4, PULSE=8, GAP=4, QUEUE=3, NUM_PLAYERS=2, INV1=8'hFF)
//  - Reset: GDB0=00, GDB1=FF, GDB3=00, coin_count=0 while Rst_n low and after release.
//  - joy_in[3] (p0 up) high for 20 cycles -> GDB0=08 exactly 7 cycles after edge;
//    3-cycle glitch -> no change.
//  - joyswap=1 with p0 up held -> GDB0=80 the next cycle; joyswap=0 -> 08.
//  - 1 coin -> GDB1[3]=0 (inverted) for 8 cycles, then 1; coin_count=1.
//  - 5 coins in quick succession -> count=4 (the first coin dequeues at once);
//    coin_drop pulses once for the 5th; then 4 pulses of 8 cycles with 4-cycle gaps.
//  - Tilt pulse of 10 cycles -> GDB1[7]=0 persists; Rst_n low mid-PULSE ->
//    GDB1=FF next cycle, FSM IDLE.

Source files
------------

// File: rtl/mw8080_input_ports.sv
`default_nettype none
// ============================================================================
// Module      : mw8080_input_ports
// Description : Player-input front end for Midway/Taito 8080 arcade cores.
//               Synchronises and debounces joystick/start/coin/tilt inputs,
//               applies joystick swap, latches tilt, counts coins and turns
//               each accepted coin into a fixed-width pulse via a small
//               saturating queue. Drives the CPU input bytes GDB0..GDB3.
// Ports       : Clk, Rst_n           clock, async active-low reset
//               joy_in[4*NP]         per player {up,down,right,left}, p0 in LSBs
//               start_in[NP]         start buttons, bit0 = 1P
//               coin_in, tilt_in     coin / tilt switches, active high
//               joyswap              swap players 0/1 (no effect if NP<2)
//               dip[8]               DIP switches, sampled once, no debounce
//               GDB0..GDB3[8]        registered CPU input bytes (XOR INV0..3)
//               coin_count[8]        accepted coins, wraps
//               coin_drop            1-cycle strobe: coin lost, queue full
// Revision    : 1.0  initial release
// ============================================================================
module mw8080_input_ports #(
    parameter int         NUM_PLAYERS       = 2,
    parameter int         DEBOUNCE_CYCLES   = 1024,
    parameter int         COIN_PULSE_CYCLES = 65536,
    parameter int         COIN_GAP_CYCLES   = 65536,
    parameter int         COIN_QUEUE        = 3,
    parameter logic [7:0] INV0              = 8'h00,
    parameter logic [7:0] INV1              = 8'h00,
    parameter logic [7:0] INV2              = 8'h00,
    parameter logic [7:0] INV3              = 8'h00
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic [4*NUM_PLAYERS-1:0]   joy_in,
    input  logic [NUM_PLAYERS-1:0]     start_in,
    input  logic                       coin_in,
    input  logic                       tilt_in,
    input  logic                       joyswap,
    input  logic [7:0]                 dip,
    output logic [7:0]                 GDB0,
    output logic [7:0]                 GDB1,
    output logic [7:0]                 GDB2,
    output logic [7:0]                 GDB3,
    output logic [7:0]                 coin_count,
    output logic                       coin_drop
);

    localparam int NB      = 5*NUM_PLAYERS + 2;
    localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMR_MAX = (COIN_PULSE_CYCLES > COIN_GAP_CYCLES) ? COIN_PULSE_CYCLES
                                                                   : COIN_GAP_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int Q_W     = $clog2(COIN_QUEUE + 1);

    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(COIN_PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(COIN_GAP_CYCLES - 1);
    localparam logic [Q_W-1:0]   Q_FULL     = Q_W'(COIN_QUEUE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } coin_state_t;

    // ------------------------------------------------------------------
    // Input synchronisers: one vector {tilt, coin, start, joy}
    // ------------------------------------------------------------------
    logic [NB-1:0] w_raw;
    logic [NB-1:0] r_sync1;
    logic [NB-1:0] r_sync2;
    logic [NB-1:0] w_stable;
    logic [7:0]    r_dip;

    assign w_raw = {tilt_in, coin_in, start_in, joy_in};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_dip   <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_dip   <= dip;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: each bit follows its synced value only after it has
    // disagreed with the stable value for DEBOUNCE_CYCLES consecutive cycles.
    // ------------------------------------------------------------------
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign w_stable = r_sync2;
    end else begin : g_debounce
        for (genvar i = 0; i < NB; i++) begin : g_bit
            logic [CNT_W-1:0] r_cnt;
            logic             r_stab;

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    r_cnt  <= '0;
                    r_stab <= 1'b0;
                end else if (r_sync2[i] != r_stab) begin
                    if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_stab <= r_sync2[i];
                        r_cnt  <= '0;
                    end else begin
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign w_stable[i] = r_stab;
        end
    end

    logic [4*NUM_PLAYERS-1:0] w_joy_db;
    logic [NUM_PLAYERS-1:0]   w_st_db;
    logic                     w_coin_db;
    logic                     w_tilt_db;

    assign w_joy_db  = w_stable[4*NUM_PLAYERS-1:0];
    assign w_st_db   = w_stable[5*NUM_PLAYERS-1:4*NUM_PLAYERS];
    assign w_coin_db = w_stable[5*NUM_PLAYERS];
    assign w_tilt_db = w_stable[5*NUM_PLAYERS+1];

    // Absent players read as zero before the output inversion.
    logic [15:0] w_joy_pad;
    logic [15:0] w_joy_sw;
    logic [3:0]  w_st_pad;

    assign w_joy_pad = 16'(w_joy_db);
    assign w_st_pad  = 4'(w_st_db);

    // Swap is taken straight from the pin so a change shows on the next cycle.
    always_comb begin
        w_joy_sw = w_joy_pad;
        if (NUM_PLAYERS >= 2 && joyswap) begin
            w_joy_sw[3:0] = w_joy_pad[7:4];
            w_joy_sw[7:4] = w_joy_pad[3:0];
        end
    end

    // ------------------------------------------------------------------
    // Edge detection, tilt latch, coin queue and counter
    // ------------------------------------------------------------------
    logic r_coin_prev;
    logic r_tilt_prev;
    logic r_tilt;
    logic w_coin_rise;
    logic w_accept;
    logic w_deq;

    logic [Q_W-1:0]   r_queue;
    logic [Q_W-1:0]   w_queue_nxt;
    coin_state_t      r_state;
    coin_state_t      w_state_nxt;
    logic [TMR_W-1:0] r_tmr;
    logic [TMR_W-1:0] w_tmr_nxt;

    assign w_coin_rise = w_coin_db & ~r_coin_prev;
    // A dequeue in the same cycle frees a slot, so a full queue still accepts.
    assign w_accept    = w_coin_rise & ((r_queue != Q_FULL) | w_deq);

    always_comb begin
        w_queue_nxt = r_queue;
        if (w_accept && !w_deq) begin
            w_queue_nxt = r_queue + Q_W'(1);
        end else if (!w_accept && w_deq) begin
            w_queue_nxt = r_queue - Q_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Coin pulse FSM. When the gap expires with coins pending, the idle
    // decision is taken in the same cycle so gaps are exactly the gap width.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_deq       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_queue != '0) begin
                    w_deq       = 1'b1;
                    w_state_nxt = S_PULSE;
                    w_tmr_nxt   = PULSE_LOAD;
                end
            end
            S_PULSE: begin
                if (r_tmr == '0) begin
                    w_state_nxt = S_GAP;
                    w_tmr_nxt   = GAP_LOAD;
                end else begin
                    w_tmr_nxt   = r_tmr - TMR_W'(1);
                end
            end
            S_GAP: begin
                if (r_tmr == '0) begin
                    if (r_queue != '0) begin
                        w_deq       = 1'b1;
                        w_state_nxt = S_PULSE;
                        w_tmr_nxt   = PULSE_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_tmr_nxt = r_tmr - TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tmr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= S_IDLE;
            r_tmr       <= '0;
            r_queue     <= '0;
            r_coin_prev <= 1'b0;
            r_tilt_prev <= 1'b0;
            r_tilt      <= 1'b0;
            coin_count  <= '0;
            coin_drop   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmr       <= w_tmr_nxt;
            r_queue     <= w_queue_nxt;
            r_coin_prev <= w_coin_db;
            r_tilt_prev <= w_tilt_db;
            if (w_tilt_db && !r_tilt_prev) begin
                r_tilt <= 1'b1;
            end
            if (w_accept) begin
                coin_count <= coin_count + 8'd1;
            end
            coin_drop   <= w_coin_rise & ~w_accept;
        end
    end

    // ------------------------------------------------------------------
    // Registered CPU input bytes
    // ------------------------------------------------------------------
    logic w_coin_bit;
    assign w_coin_bit = (r_state == S_PULSE);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            GDB0 <= INV0;
            GDB1 <= INV1;
            GDB2 <= INV2;
            GDB3 <= INV3;
        end else begin
            GDB0 <= w_joy_sw[7:0] ^ INV0;
            GDB1 <= {r_tilt, w_st_pad[3], w_st_pad[2], 1'b0,
                     w_coin_bit, 1'b0, w_st_pad[1], w_st_pad[0]} ^ INV1;
            GDB2 <= r_dip ^ INV2;
            GDB3 <= w_joy_sw[15:8] ^ INV3;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mw8080_input_ports.sv
`default_nettype none
// ============================================================================
// Module      : tb_mw8080_input_ports
// Description : Directed self-checking bench for mw8080_input_ports. A main
//               instance uses a 4-cycle debounce; a second instance with the
//               debounce bypassed lets coins arrive fast enough to fill the
//               coin queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mw8080_input_ports;

    logic       Clk   = 1'b0;
    logic       Rst_n = 1'b0;
    logic [3:0] start_in = '0;
    logic [7:0] joy_in   = '0;
    logic       coin_in  = 1'b0;
    logic       coin_f   = 1'b0;
    logic       tilt_in  = 1'b0;
    logic       joyswap  = 1'b0;
    logic [7:0] dip      = '0;

    logic [7:0] gdb0, gdb1, gdb2, gdb3, ccount;
    logic       cdrop;
    logic [7:0] gdb0_f, gdb1_f, gdb2_f, gdb3_f, ccount_f;
    logic       cdrop_f;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    mw8080_input_ports #(
        .NUM_PLAYERS(2), .DEBOUNCE_CYCLES(4), .COIN_PULSE_CYCLES(8),
        .COIN_GAP_CYCLES(4), .COIN_QUEUE(3),
        .INV0(8'h00), .INV1(8'hFF), .INV2(8'h00), .INV3(8'h00)
    ) u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .joy_in(joy_in), .start_in(start_in[1:0]),
        .coin_in(coin_in), .tilt_in(tilt_in), .joyswap(joyswap), .dip(dip),
        .GDB0(gdb0), .GDB1(gdb1), .GDB2(gdb2), .GDB3(gdb3),
        .coin_count(ccount), .coin_drop(cdrop)
    );

    mw8080_input_ports #(
        .NUM_PLAYERS(2), .DEBOUNCE_CYCLES(0), .COIN_PULSE_CYCLES(8),
        .COIN_GAP_CYCLES(4), .COIN_QUEUE(3),
        .INV0(8'h00), .INV1(8'hFF), .INV2(8'h00), .INV3(8'h00)
    ) u_dut_fast (
        .Clk(Clk), .Rst_n(Rst_n), .joy_in(joy_in), .start_in(start_in[1:0]),
        .coin_in(coin_f), .tilt_in(1'b0), .joyswap(joyswap), .dip(dip),
        .GDB0(gdb0_f), .GDB1(gdb1_f), .GDB2(gdb2_f), .GDB3(gdb3_f),
        .coin_count(ccount_f), .coin_drop(cdrop_f)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   run;
        int   changes;
        int   npulse;
        int   ndrop;
        logic found;
        logic prev;
        logic b;

        // Reset state, both during and after reset
        tick(2);
        chk("rst_gdb0", gdb0, 8'h00);
        chk("rst_gdb1", gdb1, 8'hFF);
        chk("rst_gdb3", gdb3, 8'h00);
        chk("rst_count", ccount, 8'd0);
        Rst_n = 1'b1;
        tick(3);
        chk("post_rst_gdb0", gdb0, 8'h00);
        chk("post_rst_gdb1", gdb1, 8'hFF);
        chk("post_rst_gdb3", gdb3, 8'h00);
        chk("post_rst_count", ccount, 8'd0);

        // DIP passthrough (one sample FF + output register)
        dip = 8'hA5;
        tick(2);
        chk("dip_gdb2", gdb2, 8'hA5);

        // p0 up: output changes exactly 7 cycles after the edge
        joy_in = 8'h08;
        tick(6);
        chk("joy_lat_6", gdb0, 8'h00);
        tick(1);
        chk("joy_lat_7", gdb0, 8'h08);
        chk("joy_gdb3", gdb3, 8'h00);

        // Swap without debounce
        joyswap = 1'b1;
        tick(1);
        chk("swap_on", gdb0, 8'h80);
        joyswap = 1'b0;
        tick(1);
        chk("swap_off", gdb0, 8'h08);
        tick(11);
        joy_in = 8'h00;
        tick(12);
        chk("joy_release", gdb0, 8'h00);

        // A 3-cycle glitch must not reach the output
        joy_in = 8'h08;
        tick(3);
        joy_in = 8'h00;
        changes = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (gdb0 != 8'h00) changes++;
        end
        chk("glitch_filtered", changes, 0);

        // Single coin: 8-cycle active-low pulse on GDB1[3]
        coin_in = 1'b1;
        tick(6);
        coin_in = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick(1);
            if (!gdb1[3]) found = 1'b1;
        end
        chk("coin_pulse_seen", found, 1'b1);
        run = 0;
        while (!gdb1[3] && run < 40) begin
            run++;
            tick(1);
        end
        chk("coin_pulse_width", run, 8);
        chk("coin_count_1", ccount, 8'd1);
        chk("coin_no_drop", cdrop, 1'b0);

        // Tilt: sticky after a 10-cycle pulse
        tilt_in = 1'b1;
        tick(10);
        tilt_in = 1'b0;
        tick(20);
        chk("tilt_latched", gdb1, 8'h7F);
        tick(10);
        chk("tilt_sticky", gdb1, 8'h7F);

        // Reset in the middle of a coin pulse
        coin_in = 1'b1;
        tick(6);
        coin_in = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick(1);
            if (!gdb1[3]) found = 1'b1;
        end
        chk("mid_pulse_seen", found, 1'b1);
        tick(3);
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_gdb1", gdb1, 8'hFF);
        chk("mid_rst_count", ccount, 8'd0);
        tick(1);
        Rst_n = 1'b1;
        changes = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (gdb1 != 8'hFF) changes++;
        end
        chk("after_rst_idle", changes, 0);

        // Fast coins on the bypassed instance: 5 coins, queue saturates
        npulse = 0;
        ndrop  = 0;
        run    = 0;
        prev   = 1'b1;
        for (int i = 0; i < 90; i++) begin
            coin_f = (i < 10) ? ((i % 2) == 0) : 1'b0;
            tick(1);
            if (cdrop_f) ndrop++;
            b = gdb1_f[3];
            if (!b) begin
                if (prev) begin
                    if (npulse > 0) chk("fast_gap_width", run, 4);
                    run = 0;
                    npulse++;
                end
                run++;
            end else begin
                if (!prev) begin
                    chk("fast_pulse_width", run, 8);
                    run = 0;
                end
                run++;
            end
            prev = b;
        end
        chk("fast_pulse_count", npulse, 4);
        chk("fast_drop_count", ndrop, 1);
        chk("fast_coin_count", ccount_f, 8'd4);
        chk("fast_idle_end", gdb1_f[3], 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
